// File: rtl/pipeline_pkg.sv
// Shared definitions for the EXE stage of the 5-stage MIPS core: ALU opcode
// constants, EXE FSM state encoding and the EXE/MEM boundary record.
package pipeline_pkg;

    localparam int DATA_W_DEFAULT = 32;

    localparam logic [3:0] ALUC_ADD = 4'd0;
    localparam logic [3:0] ALUC_SUB = 4'd1;
    localparam logic [3:0] ALUC_AND = 4'd2;
    localparam logic [3:0] ALUC_OR  = 4'd3;
    localparam logic [3:0] ALUC_XOR = 4'd4;
    localparam logic [3:0] ALUC_NOR = 4'd5;
    localparam logic [3:0] ALUC_SLT = 4'd6;
    localparam logic [3:0] ALUC_SLL = 4'd7;
    localparam logic [3:0] ALUC_SRL = 4'd8;
    localparam logic [3:0] ALUC_SRA = 4'd9;
    localparam logic [3:0] ALUC_LUI = 4'd10;
    localparam logic [3:0] ALUC_MUL = 4'd11;

    typedef enum logic [1:0] {
        EXE_IDLE = 2'd0,
        EXE_MUL  = 2'd1,
        EXE_DONE = 2'd2
    } exe_state_t;

    // Everything the EXE/MEM pipeline register carries
    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [31:0] alu;
        logic [31:0] store_data;
        logic [4:0]  dest;
        logic        br_taken;
        logic [31:0] br_target;
        logic [3:0]  ins_type;
        logic [3:0]  ins_number;
    } exe_mem_t;

    // Branch offset is a word offset, so scale the immediate by 4 (wraps mod 2^32)
    function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                  input logic [31:0] imm);
        return pc4 + {imm[29:0], 2'b00};
    endfunction

endpackage

// File: rtl/exe_stage_if.sv
// ID/EXE -> EXE -> EXE/MEM signal bundle. The master side is the rest of the
// pipeline (drives ID/EXE fields, sees stall and the EXE/MEM register); the
// slave side is the EXE stage itself.
interface exe_stage_if;

    // ID/EXE register contents
    logic        ewreg;
    logic        em2reg;
    logic        ewmem;
    logic [3:0]  ealuc;
    logic        eshift;
    logic        ealuimm;
    logic [31:0] odata_a;
    logic [31:0] odata_b;
    logic [31:0] odata_imm;
    logic        e_branch;
    logic [31:0] e_pc4;
    logic        e_regrt;
    logic [4:0]  e_rt;
    logic [4:0]  e_rd;
    logic [3:0]  EXE_ins_type;
    logic [3:0]  EXE_ins_number;

    // Back-pressure to ID/IF
    logic        stall;

    // EXE/MEM register contents
    logic        mwreg;
    logic        mm2reg;
    logic        mwmem;
    logic [31:0] m_alu;
    logic [31:0] m_store_data;
    logic [4:0]  m_dest;
    logic        m_br_taken;
    logic [31:0] m_br_target;
    logic [3:0]  MEM_ins_type;
    logic [3:0]  MEM_ins_number;

    modport master (
        output ewreg, em2reg, ewmem, ealuc, eshift, ealuimm,
               odata_a, odata_b, odata_imm, e_branch, e_pc4,
               e_regrt, e_rt, e_rd, EXE_ins_type, EXE_ins_number,
        input  stall,
               mwreg, mm2reg, mwmem, m_alu, m_store_data, m_dest,
               m_br_taken, m_br_target, MEM_ins_type, MEM_ins_number
    );

    modport slave (
        input  ewreg, em2reg, ewmem, ealuc, eshift, ealuimm,
               odata_a, odata_b, odata_imm, e_branch, e_pc4,
               e_regrt, e_rt, e_rd, EXE_ins_type, EXE_ins_number,
        output stall,
               mwreg, mm2reg, mwmem, m_alu, m_store_data, m_dest,
               m_br_taken, m_br_target, MEM_ins_type, MEM_ins_number
    );

endinterface

// File: rtl/iter_mul32.sv
// 32-cycle shift-and-add multiplier returning the low 32 bits of an unsigned
// product. start_i is taken only when idle; done_o marks the final iteration
// cycle, so product_o is complete on the cycle after done_o.
module iter_mul32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] product_o
);

    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;

    // Next-state: load on start, otherwise one add/shift step per busy cycle
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start_i && !busy_q) begin
            mcand_d  = a_i;
            mplier_d = b_i;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = {mcand_q[30:0], 1'b0};
            mplier_d = {1'b0, mplier_q[31:1]};
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
                busy_d = 1'b0;
            end
        end
    end

    // Multiplier state registers; reset aborts any multiply in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = busy_q && (cnt_q == 5'd31);
    assign product_o = acc_q;

endmodule

// File: rtl/exe_stage.sv
// EXE stage: operand selection, single-cycle ALU, iterative multiply with
// upstream stall, and the EXE/MEM pipeline register.
module exe_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    exe_stage_if.slave  bus
);

    logic [DATA_W-1:0]        op_a;
    logic [DATA_W-1:0]        op_b;
    logic [DATA_W-1:0]        alu_res;
    logic signed [DATA_W-1:0] sra_res;
    logic [4:0]               shamt;
    logic                     is_mul;
    logic                     bubble;
    logic                     mul_start;
    logic                     mul_busy;
    logic                     mul_done;
    logic [DATA_W-1:0]        mul_product;
    exe_state_t               state_q;
    exe_mem_t                 mem_d;
    exe_mem_t                 mem_q;

    // Operand muxes: shifts take shamt from the immediate, I-type takes imm as B
    assign op_a  = bus.eshift ? {27'd0, bus.odata_imm[10:6]} : bus.odata_a;
    assign op_b  = bus.ealuimm ? bus.odata_imm : bus.odata_b;
    assign shamt = op_a[4:0];
    assign sra_res = $signed(op_b) >>> shamt;

    assign is_mul    = (bus.ealuc == ALUC_MUL);
    assign mul_start = (state_q == EXE_IDLE) && is_mul;

    // A MUL stalls from the cycle it is first seen until the result is ready
    assign bubble    = (state_q == EXE_MUL) || mul_start;
    assign bus.stall = bubble && !rst;

    iter_mul32 u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mul_start),
        .a_i       (op_a),
        .b_i       (op_b),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    // Single-cycle ALU; MUL and unused opcodes yield 0 here
    always_comb begin
        alu_res = '0;
        case (bus.ealuc)
            ALUC_ADD: alu_res = op_a + op_b;
            ALUC_SUB: alu_res = op_a - op_b;
            ALUC_AND: alu_res = op_a & op_b;
            ALUC_OR:  alu_res = op_a | op_b;
            ALUC_XOR: alu_res = op_a ^ op_b;
            ALUC_NOR: alu_res = ~(op_a | op_b);
            ALUC_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALUC_SLL: alu_res = op_b << shamt;
            ALUC_SRL: alu_res = op_b >> shamt;
            ALUC_SRA: alu_res = sra_res;
            ALUC_LUI: alu_res = {op_b[15:0], 16'd0};
            default:  alu_res = '0;
        endcase
    end

    // EXE FSM: IDLE -> MUL for 32 iterations -> DONE (result capture) -> IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EXE_IDLE;
        end else begin
            case (state_q)
                EXE_IDLE: begin
                    if (is_mul) begin
                        state_q <= EXE_MUL;
                    end
                end
                EXE_MUL: begin
                    if (mul_done) begin
                        state_q <= EXE_DONE;
                    end else if (!mul_busy) begin
                        // multiplier lost its job (should not happen): recover
                        state_q <= EXE_IDLE;
                    end
                end
                EXE_DONE: state_q <= EXE_IDLE;
                default:  state_q <= EXE_IDLE;
            endcase
        end
    end

    // Next EXE/MEM contents: bubble while stalling, product in DONE
    always_comb begin
        mem_d            = '0;
        mem_d.wreg       = bus.ewreg;
        mem_d.m2reg      = bus.em2reg;
        mem_d.wmem       = bus.ewmem;
        mem_d.alu        = alu_res;
        mem_d.store_data = bus.odata_b;
        mem_d.dest       = bus.e_regrt ? bus.e_rt : bus.e_rd;
        mem_d.br_taken   = bus.e_branch && (bus.odata_a == bus.odata_b);
        mem_d.br_target  = branch_target(bus.e_pc4, bus.odata_imm);
        mem_d.ins_type   = bus.EXE_ins_type;
        mem_d.ins_number = bus.EXE_ins_number;
        if (state_q == EXE_DONE) begin
            mem_d.alu = mul_product;
        end else if (bubble) begin
            mem_d = '0;
        end
    end

    // EXE/MEM pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign bus.mwreg          = mem_q.wreg;
    assign bus.mm2reg         = mem_q.m2reg;
    assign bus.mwmem          = mem_q.wmem;
    assign bus.m_alu          = mem_q.alu;
    assign bus.m_store_data   = mem_q.store_data;
    assign bus.m_dest         = mem_q.dest;
    assign bus.m_br_taken     = mem_q.br_taken;
    assign bus.m_br_target    = mem_q.br_target;
    assign bus.MEM_ins_type   = mem_q.ins_type;
    assign bus.MEM_ins_number = mem_q.ins_number;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed cases plus randomized
// instructions checked against a behavioural model of the EXE stage.
module tb_exe_stage;
    import pipeline_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exe_stage_if bus ();

    exe_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit        wreg, m2reg, wmem;
        bit [3:0]  aluc;
        bit        shift, aluimm;
        bit [31:0] a, b, imm;
        bit        branch;
        bit [31:0] pc4;
        bit        regrt;
        bit [4:0]  rt, rd;
        bit [3:0]  typ, num;
    } instr_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic instr_t mk(input bit [3:0] aluc, input bit [31:0] a,
                                  input bit [31:0] b, input bit [31:0] imm);
        instr_t t;
        t = '{default: 0};
        t.aluc = aluc; t.a = a; t.b = b; t.imm = imm;
        t.wreg = 1'b1; t.rt = 5'd9; t.rd = 5'd3; t.pc4 = 32'h100;
        t.typ = 4'd1; t.num = 4'd2;
        return t;
    endfunction

    function automatic instr_t rand_instr(input bit want_mul);
        instr_t t;
        t.wreg   = 1'($urandom);
        t.m2reg  = 1'($urandom);
        t.wmem   = 1'($urandom);
        t.aluc   = 4'($urandom_range(0, 15));
        if (t.aluc == 4'd11) t.aluc = 4'd0;
        if (want_mul) t.aluc = 4'd11;
        t.shift  = 1'($urandom);
        t.aluimm = 1'($urandom);
        t.a      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        t.b      = ($urandom_range(0, 3) == 0) ? t.a : $urandom;
        t.imm    = $urandom;
        t.branch = 1'($urandom);
        t.pc4    = $urandom;
        t.regrt  = 1'($urandom);
        t.rt     = 5'($urandom);
        t.rd     = 5'($urandom);
        t.typ    = 4'($urandom);
        t.num    = 4'($urandom);
        return t;
    endfunction

    // Behavioural model of the result an instruction should leave in EXE/MEM
    function automatic bit [31:0] model_result(input instr_t t);
        bit [31:0] x, y;
        bit [63:0] p;
        int unsigned s;
        x = t.shift ? {27'd0, t.imm[10:6]} : t.a;
        y = t.aluimm ? t.imm : t.b;
        s = x % 32;
        case (t.aluc)
            4'd0:  return x + y;
            4'd1:  return x - y;
            4'd2:  return x & y;
            4'd3:  return x | y;
            4'd4:  return x ^ y;
            4'd5:  return ~(x | y);
            4'd6:  return (int'(x) < int'(y)) ? 32'd1 : 32'd0;
            4'd7:  return y << s;
            4'd8:  return y >> s;
            4'd9:  return (y >> s) | (y[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
            4'd10: return y * 32'd65536;
            4'd11: begin
                p = 64'(x) * 64'(y);
                return p[31:0];
            end
            default: return 32'd0;
        endcase
    endfunction

    task automatic apply(input instr_t t);
        bus.ewreg = t.wreg; bus.em2reg = t.m2reg; bus.ewmem = t.wmem;
        bus.ealuc = t.aluc; bus.eshift = t.shift; bus.ealuimm = t.aluimm;
        bus.odata_a = t.a; bus.odata_b = t.b; bus.odata_imm = t.imm;
        bus.e_branch = t.branch; bus.e_pc4 = t.pc4; bus.e_regrt = t.regrt;
        bus.e_rt = t.rt; bus.e_rd = t.rd;
        bus.EXE_ins_type = t.typ; bus.EXE_ins_number = t.num;
    endtask

    // Issue one instruction, wait out any stall, check what lands in EXE/MEM.
    // Called and returns at 1ns after a rising edge.
    task automatic run(input instr_t t, input string name);
        int st;
        int bub;
        int exp_st;
        apply(t);
        #1;
        st  = 0;
        bub = 0;
        while (bus.stall === 1'b1 && st < 100) begin
            st++;
            @(posedge clk);
            #1;
            if (bus.mwreg || bus.mwmem || bus.mm2reg || bus.m_br_taken) bub++;
        end
        exp_st = (t.aluc == 4'd11) ? 33 : 0;
        check({name, "_stall_len"}, 32'(st), 32'(exp_st));
        if (t.aluc == 4'd11) check({name, "_bubble"}, 32'(bub), 32'd0);
        @(posedge clk);
        #1;
        check({name, "_alu"},    bus.m_alu, model_result(t));
        check({name, "_dest"},   32'(bus.m_dest), 32'(t.regrt ? t.rt : t.rd));
        check({name, "_ctrl"},   32'({bus.mwreg, bus.mm2reg, bus.mwmem}),
                                 32'({t.wreg, t.m2reg, t.wmem}));
        check({name, "_store"},  bus.m_store_data, t.b);
        check({name, "_br"},     32'(bus.m_br_taken), 32'(t.branch && (t.a == t.b)));
        check({name, "_target"}, bus.m_br_target, t.pc4 + t.imm * 32'd4);
        check({name, "_tags"},   32'({bus.MEM_ins_type, bus.MEM_ins_number}),
                                 32'({t.typ, t.num}));
        $display("[%0t] %s aluc=%0d a=%h b=%h imm=%h stall=%0d -> m_alu=%h dest=%0d",
                 $time, name, t.aluc, t.a, t.b, t.imm, st, bus.m_alu, bus.m_dest);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        instr_t t;

        // Reset state
        rst = 1'b1;
        apply(mk(ALUC_ADD, 32'd0, 32'd0, 32'd0));
        repeat (2) @(posedge clk);
        #1;
        check("reset_alu",   bus.m_alu, 32'd0);
        check("reset_ctrl",  32'({bus.mwreg, bus.mm2reg, bus.mwmem, bus.m_br_taken}), 32'd0);
        check("reset_stall", 32'(bus.stall), 32'd0);
        check("reset_tgt",   bus.m_br_target, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ALU coverage
        run(mk(ALUC_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0), "add_wrap");
        check("add_wrap_lit", bus.m_alu, 32'd0);
        run(mk(ALUC_SUB, 32'd5, 32'd7, 32'd0), "sub");
        check("sub_lit", bus.m_alu, 32'hFFFF_FFFE);
        run(mk(ALUC_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0), "slt");
        check("slt_lit", bus.m_alu, 32'd1);
        t = mk(ALUC_SRA, 32'd0, 32'h8000_0000, 32'h0000_0100);
        t.shift = 1'b1;
        run(t, "sra");
        check("sra_lit", bus.m_alu, 32'hF800_0000);
        t = mk(ALUC_LUI, 32'd0, 32'd0, 32'h0000_1234);
        t.aluimm = 1'b1;
        run(t, "lui");
        check("lui_lit", bus.m_alu, 32'h1234_0000);

        // Immediate operand and rt destination
        t = mk(ALUC_ADD, 32'h20, 32'd0, 32'hFFFF_FFF0);
        t.aluimm = 1'b1;
        t.regrt  = 1'b1;
        run(t, "imm_sel");
        check("imm_sel_lit_alu",  bus.m_alu, 32'h10);
        check("imm_sel_lit_dest", 32'(bus.m_dest), 32'd9);
        check("imm_sel_lit_wreg", 32'(bus.mwreg), 32'd1);

        // Multiply, then back-to-back multiplies
        run(mk(ALUC_MUL, 32'h0001_0003, 32'd5, 32'd0), "mul");
        check("mul_lit", bus.m_alu, 32'h0005_000F);
        check("mul_lit_wreg", 32'(bus.mwreg), 32'd1);
        run(mk(ALUC_MUL, 32'd7, 32'd6, 32'd0), "mul_b2b_1");
        check("mul_b2b_1_lit", bus.m_alu, 32'd42);
        run(mk(ALUC_MUL, 32'hFFFF_FFFF, 32'd2, 32'd0), "mul_b2b_2");
        check("mul_b2b_2_lit", bus.m_alu, 32'hFFFF_FFFE);

        // Branch decision and target
        t = mk(ALUC_ADD, 32'h55, 32'h55, 32'hFFFF_FFFF);
        t.branch = 1'b1;
        run(t, "beq_taken");
        check("beq_taken_lit", 32'(bus.m_br_taken), 32'd1);
        check("beq_target_lit", bus.m_br_target, 32'h0000_00FC);
        t.b = 32'h56;
        run(t, "beq_not");
        check("beq_not_lit", 32'(bus.m_br_taken), 32'd0);

        // Reset in the middle of a multiply
        apply(mk(ALUC_MUL, 32'd3, 32'd4, 32'd0));
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_stall", 32'(bus.stall), 32'd0);
        check("rst_mid_alu",   bus.m_alu, 32'd0);
        check("rst_mid_ctrl",  32'({bus.mwreg, bus.mm2reg, bus.mwmem, bus.m_br_taken}), 32'd0);
        check("rst_mid_dest",  32'(bus.m_dest), 32'd0);
        apply(mk(ALUC_ADD, 32'd1, 32'd2, 32'd0));
        #1;
        check("rst_hold_stall", 32'(bus.stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_after_alu",  bus.m_alu, 32'd3);
        check("rst_after_wreg", 32'(bus.mwreg), 32'd1);

        // Randomized traffic with occasional multiplies
        for (int i = 0; i < 80; i++) begin
            t = rand_instr((i % 20) == 7);
            run(t, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Consumer end of the ID/EXE pipeline register in the 5-stage MIPS core.
- Takes the registered EXE-side control and data fields, selects ALU operands and computes the result.
- Runs a 32-cycle iterative multiply, asserting stall back to ID/IF while it is busy.
- Registers everything into the EXE/MEM boundary: branch decision, store data, destination register and debug tags.

Parameters:
- DATA_W, 32, datapath width. Fixed at 32; the multiply counter and shift fields assume it.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ewreg, em2reg, ewmem  in  1 each  control bits from ID/EXE
- ealuc  in  4  ALU opcode
- eshift  in  1  shift instruction: shamt taken from imm[10:6]
- ealuimm  in  1  B operand = immediate
- odata_a, odata_b, odata_imm  in  32 each  rs value, rt value, sign-extended immediate
- e_branch  in  1  BEQ instruction
- e_pc4  in  32  PC+4 of the instruction
- e_regrt  in  1  destination = rt (else rd)
- e_rt, e_rd  in  5 each  register numbers
- EXE_ins_type, EXE_ins_number  in  4 each  debug tags
- stall  out  1  combinational; upstream holds PC, IF/ID and ID/EXE while high
- mwreg, mm2reg, mwmem  out  1 each  registered control to MEM
- m_alu  out  32  registered ALU/multiply result
- m_store_data  out  32  registered odata_b
- m_dest  out  5  registered destination register
- m_br_taken  out  1  registered: e_branch & (odata_a==odata_b)
- m_br_target  out  32  registered: e_pc4 + (odata_imm<<2), mod 2^32
- MEM_ins_type, MEM_ins_number  out  4 each  registered debug tags

Behaviour:
- Reset: every registered output is 0, the FSM is IDLE and stall=0. Reset asserted mid-multiply aborts the multiply with no write.
- Operand A:
  - eshift=1: {27'b0, odata_imm[10:6]}
  - otherwise: odata_a
- Operand B:
  - ealuimm=1: odata_imm
  - otherwise: odata_b
- ealuc decode:
  - 0 ADD, 1 SUB: wrap mod 2^32, no overflow trap
  - 2 AND, 3 OR, 4 XOR, 5 NOR
  - 6 SLT: signed compare, result 1/0
  - 7 SLL, 8 SRL, 9 SRA: shift B by A[4:0]
  - 10 LUI: B<<16
  - 11 MUL: low 32 bits of unsigned A*B
  - 12-15: result 0
- Non-MUL ops: single cycle; EXE/MEM captures on the next rising edge. stall stays 0.
- FSM states IDLE, MUL, DONE:
  - IDLE & ealuc==MUL: stall=1 combinationally. At the clock edge load multiplicand=A, multiplier=B, acc=0, cnt=0, then go to MUL. EXE/MEM captures a bubble: mwreg=mwmem=mm2reg=0, m_br_taken=0, other fields don't-care but deterministic.
  - MUL: stall=1. Each cycle: if multiplier[0], acc+=multiplicand; multiplicand<<=1; multiplier>>=1; cnt++. After the cnt==31 iteration go to DONE. Bubble into EXE/MEM every cycle.
  - DONE: stall=0. EXE/MEM captures m_alu=acc plus the instruction's own control fields. Next state IDLE.
  - Net result: a MUL holds stall high for 33 cycles, and its result appears at MEM 34 edges after it enters EXE.
  - Back-to-back MUL: the second MUL is seen in IDLE on the cycle after DONE and restarts the sequence normally.
- Operands A and B are sampled only at MUL start; the ID/EXE contents are frozen during the stall anyway.
- Branch: m_br_taken compares raw odata_a and odata_b, ignoring operand muxing. Flushing younger instructions is handled by the hazard unit, not here.
- m_dest = e_regrt ? e_rt : e_rd. No forced-zero handling; writes to r0 are suppressed downstream.

Decomposition:
- pipeline_pkg:
  - ALUC_* 4-bit opcode constants (0-11)
  - exe FSM state encoding (IDLE=2'd0, MUL=2'd1, DONE=2'd2)
  - DATA_W default
- One sub-module, iter_mul32: start/busy/done handshake, 5-bit counter, acc/multiplicand/multiplier registers, async reset.
- exe_stage holds the operand muxes, ALU, FSM/stall logic and the EXE/MEM register.

Test Plan:
- Reset mid-multiply: assert rst during MUL cycle 10 -> all outputs 0 and stall=0 immediately; after release an ADD 1+2 produces m_alu=3 on the next edge.
- ALU coverage:
  - ADD 0xFFFFFFFF+1 -> m_alu=0.
  - SUB 5-7 -> 0xFFFFFFFE.
  - SLT -1<1 -> 1.
  - SRA 0x80000000 by imm[10:6]=4 with eshift=1 -> 0xF8000000.
  - LUI imm=0x1234 -> 0x12340000.
- Immediate/dest select: ealuimm=1, imm=0xFFFFFFF0, A=0x20, e_regrt=1, rt=9, rd=3 -> m_alu=0x10, m_dest=9, mwreg passed through.
- Multiply: MUL 0x0001_0003 * 0x0000_0005 -> stall high exactly 33 cycles, bubbles (mwreg=0) during the stall, then m_alu=0x0005_000F with mwreg=1.
- Back-to-back MUL: 7*6 then 0xFFFFFFFF*2 -> results 42 and 0xFFFFFFFE, each preceded by a 33-cycle stall.
- Branch: e_branch=1, a=b=0x55, pc4=0x100, imm=0xFFFFFFFF -> m_br_taken=1, m_br_target=0xFC. With a≠b -> m_br_taken=0.
